// File: rtl/data_mem_wait_ctrl_if.sv
// CPU <-> data memory request/response bundle; the CPU drives requests and the memory stage drives results.
// Handshake: request pulses sampled while not busy, completion reported as a one-cycle ready pulse.
interface data_mem_wait_ctrl_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                req_read;
    logic                req_write;
    logic [ADDR_LEN-1:0] addr;
    logic [DATA_LEN-1:0] wdata;
    logic [DATA_LEN-1:0] rdata;
    logic                ready;
    logic                busy;
    logic                err;

    modport master (
        output req_read, req_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req_read, req_write, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/data_mem_wait_ctrl.sv
// Variable-latency word memory: accepts one read/write in IDLE, completes LATENCY edges later with a one-cycle ready pulse.
// Requests while busy are dropped; optional misalignment trap via DATA_MEM_ALIGN_CHECK_EN (suppresses access, pulses err).
module data_mem_wait_ctrl #(
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_wait_ctrl_if.slave bus
);
    localparam int             DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_WAIT   = 1'b1;
    localparam logic [3:0]     CNT_INIT = 4'(LATENCY - 1);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DATA_LEN-1:0]   wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [DATA_LEN-1:0]   rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic [DATA_LEN-1:0]   mem [DEPTH];

    logic accept;
    logic done;
    logic access_ok;
    logic unused_addr_bits;

    assign accept = (state_q == S_IDLE) && (bus.req_read || bus.req_write);
    assign done   = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic mis_q;
    logic err_q;

    assign access_ok        = !mis_q;
    assign unused_addr_bits = ^bus.addr[ADDR_LEN-1:DEPTH_LOG2+2];
    assign bus.err          = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                mis_q <= (bus.addr[1:0] != 2'b00);
            end
            err_q <= done && mis_q;
        end
    end
`else
    // Byte offset is meaningless here: accesses go to the containing word.
    assign access_ok        = 1'b1;
    assign unused_addr_bits = ^{bus.addr[ADDR_LEN-1:DEPTH_LOG2+2], bus.addr[1:0]};
    assign bus.err          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = bus.addr[DEPTH_LOG2+1:2];
                    wdata_d = bus.wdata;
                    wr_d    = bus.req_write;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    if (!wr_q && access_ok) begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Reset wipes the array so an aborted or stale write can never leak through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (done && wr_q && access_ok) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = (state_q == S_WAIT);
endmodule

// File: tb/tb_data_mem_wait_ctrl.sv
// Directed bench for data_mem_wait_ctrl with default parameters (32-bit words, 256 entries, LATENCY=3).
module tb_data_mem_wait_ctrl;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    data_mem_wait_ctrl_if #(.DATA_LEN(32), .ADDR_LEN(32)) bus ();

    data_mem_wait_ctrl #(
        .DATA_LEN(32), .ADDR_LEN(32), .DEPTH_LOG2(8), .LATENCY(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Presents one request, returns edges from acceptance to the ready cycle (-1 on timeout).
    // Returns positioned #1 after the edge that raised ready.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int cycles);
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        @(posedge clk); #1;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        cycles = 0;
        while (bus.ready !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (bus.ready !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b0;
        bus.req_write = 1'b1;
        bus.req_read  = 1'b0;
        bus.addr      = 32'h10;
        bus.wdata     = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        bus.req_write = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'h10, 32'h0, cyc);
        checks++; if (cyc !== LAT) begin failures++; $display("FAIL reset_read_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", bus.rdata); end
    endtask

    task automatic test_latency();
        int cyc;
        bus.req_write = 1'b1;
        bus.addr      = 32'h20;
        bus.wdata     = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.req_write = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL latency_busy_T%0d busy=%b ready=%b exp busy=1 ready=0", k, bus.busy, bus.ready);
            end
            if (k < LAT - 1) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL latency_done ready=%b busy=%b exp ready=1 busy=0", bus.ready, bus.busy);
        end
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL latency_pulse_width ready=%b exp=0", bus.ready); end
        issue(1'b1, 1'b0, 32'h20, 32'h0, cyc);
        checks++; if (cyc !== LAT) begin failures++; $display("FAIL latency_read_cycles got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL latency_read_data got=%h exp=deadbeef", bus.rdata); end
    endtask

    task automatic test_wrap();
        int cyc;
        issue(1'b0, 1'b1, 32'h400, 32'h1, cyc);
        issue(1'b1, 1'b0, 32'h000, 32'h0, cyc);
        checks++; if (bus.rdata !== 32'h1) begin failures++; $display("FAIL wrap_read got=%h exp=1", bus.rdata); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(1'b0, 1'b1, 32'h60, 32'hA5A5_0001, cyc);
        // Next request is presented during the ready cycle and must be accepted at that edge.
        issue(1'b1, 1'b0, 32'h60, 32'h0, cyc);
        checks++; if (cyc !== LAT) begin failures++; $display("FAIL b2b_cycles got=%0d exp=%0d", cyc, LAT); end
        checks++; if (bus.rdata !== 32'hA5A5_0001) begin failures++; $display("FAIL b2b_data got=%h exp=a5a50001", bus.rdata); end
    endtask

    task automatic test_collision();
        int cyc;
        issue(1'b1, 1'b0, 32'h000, 32'h0, cyc);
        issue(1'b1, 1'b1, 32'h30, 32'h5, cyc);
        checks++; if (bus.rdata !== 32'h1) begin failures++; $display("FAIL collision_rdata got=%h exp=1", bus.rdata); end
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL collision_single_pulse ready=%b exp=0", bus.ready); end
        issue(1'b1, 1'b0, 32'h30, 32'h0, cyc);
        checks++; if (bus.rdata !== 32'h5) begin failures++; $display("FAIL collision_readback got=%h exp=5", bus.rdata); end
    endtask

    task automatic test_busy_abort();
        int cyc;
        int seen;
        bus.req_write = 1'b1;
        bus.addr      = 32'h50;
        bus.wdata     = 32'h3;
        @(posedge clk); #1;
        bus.addr  = 32'h40;
        bus.wdata = 32'hAA;
        repeat (2) @(posedge clk);
        #1;
        bus.req_write = 1'b0;
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL busy_inflight_done ready=%b exp=1", bus.ready); end
        issue(1'b1, 1'b0, 32'h40, 32'h0, cyc);
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL busy_ignored got=%h exp=0", bus.rdata); end
        issue(1'b1, 1'b0, 32'h50, 32'h0, cyc);
        checks++; if (bus.rdata !== 32'h3) begin failures++; $display("FAIL busy_captured got=%h exp=3", bus.rdata); end

        bus.req_write = 1'b1;
        bus.addr      = 32'h44;
        bus.wdata     = 32'h7;
        @(posedge clk); #1;
        bus.req_write = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_state busy=%b ready=%b rdata=%h exp 0/0/0", bus.busy, bus.ready, bus.rdata);
        end
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_ready got=%0d exp=0", seen); end
        issue(1'b1, 1'b0, 32'h44, 32'h0, cyc);
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL abort_no_write got=%h exp=0", bus.rdata); end
        issue(1'b1, 1'b0, 32'h50, 32'h0, cyc);
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL abort_mem_cleared got=%h exp=0", bus.rdata); end
    endtask

    task automatic test_align();
        int cyc;
        issue(1'b0, 1'b1, 32'h20, 32'h9, cyc);
        issue(1'b1, 1'b0, 32'h00, 32'h0, cyc);
        issue(1'b1, 1'b0, 32'h22, 32'h0, cyc);
        checks++; if (cyc !== LAT) begin failures++; $display("FAIL align_cycles got=%0d exp=%0d", cyc, LAT); end
`ifdef DATA_MEM_ALIGN_CHECK_EN
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL align_err got=%b exp=1", bus.err); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL align_rdata_kept got=%h exp=0", bus.rdata); end
        @(posedge clk); #1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL align_err_pulse got=%b exp=0", bus.err); end
`else
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL align_err got=%b exp=0", bus.err); end
        checks++; if (bus.rdata !== 32'h9) begin failures++; $display("FAIL align_rdata got=%h exp=9", bus.rdata); end
`endif
    endtask

    initial begin
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_collision();
        test_busy_abort();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
